light_sequencer: RTL and testbench
==================================

Name: light_sequencer

Overview:
Queues key codes from the keyboard front end and presents them one at a time to the LED colour decoder's 8-bit selection input. Each key is held for a programmable duration, followed by a blank gap, so that rapid or repeated keypresses each appear as a distinct flash. It sits between the UART/keyboard byte source and the light decoder. It provides ready/valid flow control, filters out unmapped keys, and supports a synchronous flush.

Parameters:
HOLD_CYCLES, 5000000, clock cycles a key stays on outSel (minimum 1; 50 ms at 100 MHz).
GAP_CYCLES, 500000, clock cycles outSel is forced to 0x00 after each hold (minimum 1).
FIFO_DEPTH, 4, key queue depth (power of 2, minimum 2).
CNT_W, 24, timer width; must hold max(HOLD_CYCLES, GAP_CYCLES)-1.

Ports:
clk  in  1  master clock.
rstb  in  1  reset; asynchronous, active-low.
inKey  in  8  ASCII key code from the keyboard source.
inValid  in  1  inKey is valid this cycle.
outReady  out  1  block accepts inKey this cycle; a transfer happens when inValid & outReady.
inFlush  in  1  synchronous clear of the queue and current display.
outSel  out  8  registered key code for the light decoder; 0x00 means blank.
outBusy  out  1  high while the state is not IDLE or the queue is non-empty.
outCount  out  clog2(FIFO_DEPTH)+1  queue occupancy.
outInvalid  out  1  one-cycle pulse when an accepted byte is not a mapped key.

Behaviour:
- Reset (rstb low, asynchronous):
  - State goes to IDLE; queue is emptied; timer is cleared.
  - outSel=0x00, outBusy=0, outCount=0, outInvalid=0.
  - outReady=1 from the reset release onward.
- Mapped keys: 0x7A z, 0x73 s, 0x78 x, 0x64 d, 0x63 c, 0x76 v, 0x67 g, 0x62 b, 0x68 h, 0x6E n, 0x6A j, 0x6D m.
  - Any other accepted byte is consumed but not queued.
  - Such a byte raises outInvalid for exactly 1 cycle (the cycle after acceptance).
- outReady = !full & !inFlush. A pop in the same cycle does not free a slot for a same-cycle push.
- Push: on an accepted mapped key, the key is written at the tail and outCount increments the next cycle.
- State machine (IDLE, HOLD, GAP):
  - IDLE: outSel=0x00. If the queue is non-empty: pop the head, register it to outSel, load timer=HOLD_CYCLES-1, go to HOLD.
  - HOLD: outSel holds the key and the timer decrements. At timer==0: outSel<=0x00, timer=GAP_CYCLES-1, go to GAP.
  - GAP: outSel=0x00 and the timer decrements. At timer==0: if the queue is non-empty, pop and go directly to HOLD (same action as IDLE); otherwise go to IDLE.
- Latency:
  - A key accepted in cycle N into an empty, idle block appears on outSel from cycle N+2.
  - It stays for exactly HOLD_CYCLES cycles, followed by exactly GAP_CYCLES cycles of 0x00.
- Back-to-back keys: the next key appears exactly HOLD_CYCLES+GAP_CYCLES cycles after the previous one. There are no extra IDLE cycles between them.
- A repeated identical key still gets the full gap, so it is seen as two flashes.
- Simultaneous push and pop: both take effect; outCount is unchanged.
- Pop when the queue is empty: never occurs. Push when full: never occurs, because outReady gates it.
- Pointers wrap modulo FIFO_DEPTH. outCount distinguishes full (==FIFO_DEPTH) from empty (==0).
- Flush (inFlush high at a clock edge):
  - The next cycle has state IDLE, queue empty, outSel=0x00, timer=0.
  - A byte presented during flush is not accepted.
  - Flush has priority over every other event.
- Reset mid-HOLD or mid-GAP aborts immediately with no completion of the current flash.
- outBusy is registered and consistent with state/outCount in the same cycle.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=2, FIFO_DEPTH=4):
1. Push 0x7A at cycle 0 → outSel=0x7A in cycles 2–5, 0x00 in 6–7; outBusy falls at cycle 8; outCount is 1 at cycle 1 and 0 at cycle 2.
2. Push 0x7A at cycle 0 and 0x78 at cycle 1 → 0x7A in cycles 2–5, 0x00 in 6–7, 0x78 in 8–11, 0x00 in 12–13; then IDLE.
3. Push 0x7A, 0x73, 0x78, 0x64, 0x63, 0x76 at consecutive cycles with inValid held → outReady=0 while outCount==4. The sixth key is accepted only after the cycle-8 pop frees a slot. Display order is preserved and no key is lost or duplicated.
4. Push 0x61 ('a') → outReady=1 and the byte is accepted; outInvalid=1 for 1 cycle; outCount stays 0; outSel stays 0x00.
5. Queue 3 keys, then assert inFlush during HOLD with inValid=1 and inKey=0x6D → next cycle outSel=0x00, outCount=0, outBusy=0, state IDLE; 0x6D is never displayed.
6. Drop rstb low asynchronously mid-GAP with 2 keys queued → outputs take their reset values before the next clk edge. After release, outReady=1 and nothing is displayed until a new push.

Source files
------------

// File: rtl/light_sequencer.sv
// Key-code sequencer: queues keys and flashes each one on outSel
// for HOLD_CYCLES, then blanks for GAP_CYCLES before the next.
module light_sequencer #(
    parameter int HOLD_CYCLES = 5000000,
    parameter int GAP_CYCLES  = 500000,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 24
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic [7:0]                  inKey,
    input  logic                        inValid,
    output logic                        outReady,
    input  logic                        inFlush,
    output logic [7:0]                  outSel,
    output logic                        outBusy,
    output logic [$clog2(FIFO_DEPTH):0] outCount,
    output logic                        outInvalid
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } stateType;

    stateType         state;
    logic [CNT_W-1:0] timer;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;

    logic             isMapped;
    logic             accept;
    logic             push;
    logic             pop;
    logic             timerDone;
    logic [AW:0]      countNext;
    logic             idleNext;

    // Recognise the twelve keys that have a colour assigned.
    always_comb begin
        isMapped = 1'b0;
        case (inKey)
            8'h7A, 8'h73, 8'h78, 8'h64,
            8'h63, 8'h76, 8'h67, 8'h62,
            8'h68, 8'h6E, 8'h6A, 8'h6D: isMapped = 1'b1;
            default: isMapped = 1'b0;
        endcase
    end

    // A pop never frees a slot for the same cycle's push.
    assign outReady  = (outCount != FULL_CNT) && !inFlush;
    assign accept    = inValid && outReady;
    assign push      = accept && isMapped;
    assign timerDone = (timer == '0);

    // Pop whenever the display is free: idle, or end of a gap.
    assign pop = !inFlush && (outCount != '0) &&
                 ((state == IDLE) || ((state == GAP) && timerDone));

    // Next occupancy and whether the FSM lands in IDLE; feeds outBusy.
    always_comb begin
        countNext = outCount;
        idleNext  = 1'b0;
        if (inFlush) begin
            countNext = '0;
            idleNext  = 1'b1;
        end else begin
            unique case ({push, pop})
                2'b10:   countNext = outCount + (AW+1)'(1);
                2'b01:   countNext = outCount - (AW+1)'(1);
                default: countNext = outCount;
            endcase
            if ((state == IDLE) && !pop)
                idleNext = 1'b1;
            if ((state == GAP) && timerDone && !pop)
                idleNext = 1'b1;
        end
    end

    // Key storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push)
            mem[wrPtr] <= inKey;
    end

    // Queue pointers and occupancy; pointers wrap at FIFO_DEPTH.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            outCount <= '0;
        end else if (inFlush) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            outCount <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + AW'(1);
            if (pop)
                rdPtr <= rdPtr + AW'(1);
            outCount <= countNext;
        end
    end

    // Display FSM: IDLE -> HOLD (key shown) -> GAP (blank) -> ...
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state  <= IDLE;
            timer  <= '0;
            outSel <= 8'h00;
        end else if (inFlush) begin
            state  <= IDLE;
            timer  <= '0;
            outSel <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        outSel <= mem[rdPtr];
                        timer  <= HOLD_LOAD;
                        state  <= HOLD;
                    end else begin
                        outSel <= 8'h00;
                    end
                end
                HOLD: begin
                    if (timerDone) begin
                        outSel <= 8'h00;
                        timer  <= GAP_LOAD;
                        state  <= GAP;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (timerDone) begin
                        if (pop) begin
                            outSel <= mem[rdPtr];
                            timer  <= HOLD_LOAD;
                            state  <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    timer  <= '0;
                    outSel <= 8'h00;
                end
            endcase
        end
    end

    // Registered status flags, derived from next-cycle state and count.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            outBusy    <= 1'b0;
            outInvalid <= 1'b0;
        end else if (inFlush) begin
            outBusy    <= 1'b0;
            outInvalid <= 1'b0;
        end else begin
            outBusy    <= !idleNext || (countNext != '0);
            outInvalid <= accept && !isMapped;
        end
    end

endmodule

// File: tb/tb_light_sequencer.sv
// Self-checking bench for light_sequencer: directed table, corner
// sequences and random traffic against a timeline-based model.
module tb_light_sequencer;

    localparam int H = 4;
    localparam int G = 2;
    localparam int D = 4;
    localparam int NONE = -1000;
    localparam logic [7:0] KEYS [12] = '{
        8'h7A, 8'h73, 8'h78, 8'h64, 8'h63, 8'h76,
        8'h67, 8'h62, 8'h68, 8'h6E, 8'h6A, 8'h6D
    };

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic [7:0] inKey = 8'h00;
    logic       inValid = 1'b0;
    logic       inFlush = 1'b0;
    logic       outReady;
    logic [7:0] outSel;
    logic       outBusy;
    logic [2:0] outCount;
    logic       outInvalid;

    light_sequencer #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .FIFO_DEPTH (D),
        .CNT_W      (24)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .inKey     (inKey),
        .inValid   (inValid),
        .outReady  (outReady),
        .inFlush   (inFlush),
        .outSel    (outSel),
        .outBusy   (outBusy),
        .outCount  (outCount),
        .outInvalid(outInvalid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: key queue plus the start cycle of the current flash.
    int         t = 0;
    logic [7:0] q [$];
    int         dispStart = NONE;
    logic [7:0] dispKey = 8'h00;
    bit         mInv = 1'b0;
    bit         lastAcc = 1'b0;

    logic [7:0] seen [$];
    logic [7:0] prevSel = 8'h00;
    logic [7:0] sSel;
    int         sCnt;
    bit         sBusy;
    bit         sInv;

    typedef struct {
        bit         v;
        logic [7:0] k;
        bit         f;
        logic [7:0] sel;
        int         cnt;
        bit         busy;
    } vecT;

    vecT vecs [16];

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s t=%0d: got %0h, expected %0h",
                     name, t, act, exp);
        end
    endtask

    function automatic bit mapped(logic [7:0] k);
        foreach (KEYS[i])
            if (KEYS[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] mSel();
        if (dispStart != NONE && t >= dispStart && t < dispStart + H)
            return dispKey;
        return 8'h00;
    endfunction

    function automatic bit mBusy();
        if (q.size() != 0) return 1'b1;
        return (dispStart != NONE) && (t < dispStart + H + G);
    endfunction

    function automatic void mReset();
        q.delete();
        dispStart = NONE;
        mInv = 1'b0;
    endfunction

    // One clock cycle: sample outputs, drive inputs, advance model.
    task automatic step(bit v, logic [7:0] k, bit f);
        bit acc;
        @(negedge clk);
        sSel  = outSel;
        sCnt  = int'(outCount);
        sBusy = outBusy;
        sInv  = outInvalid;
        chk("outSel", int'(outSel), int'(mSel()));
        chk("outCount", int'(outCount), q.size());
        chk("outBusy", int'(outBusy), int'(mBusy()));
        chk("outInvalid", int'(outInvalid), int'(mInv));
        if (outSel != 8'h00 && prevSel == 8'h00)
            seen.push_back(outSel);
        prevSel = outSel;
        inValid = v;
        inKey   = k;
        inFlush = f;
        #1;
        chk("outReady", int'(outReady),
            int'((q.size() < D) && !f));
        acc = v && (q.size() < D) && !f;
        if (f) begin
            mReset();
        end else begin
            if (q.size() > 0 &&
                (dispStart == NONE || t >= dispStart + H + G - 1)) begin
                dispKey   = q.pop_front();
                dispStart = t + 1;
            end
            if (acc && mapped(k))
                q.push_back(k);
            mInv = acc && !mapped(k);
        end
        lastAcc = acc;
        t++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] t3keys [6];
        int idx;
        int acc6;
        int startT;

        // Two back-to-back keys: timeline fixed by hand.
        vecs[0]  = '{1, 8'h7A, 0, 8'h00, 0, 0};
        vecs[1]  = '{1, 8'h78, 0, 8'h00, 1, 1};
        vecs[2]  = '{0, 8'h00, 0, 8'h7A, 1, 1};
        vecs[3]  = '{0, 8'h00, 0, 8'h7A, 1, 1};
        vecs[4]  = '{0, 8'h00, 0, 8'h7A, 1, 1};
        vecs[5]  = '{0, 8'h00, 0, 8'h7A, 1, 1};
        vecs[6]  = '{0, 8'h00, 0, 8'h00, 1, 1};
        vecs[7]  = '{0, 8'h00, 0, 8'h00, 1, 1};
        vecs[8]  = '{0, 8'h00, 0, 8'h78, 0, 1};
        vecs[9]  = '{0, 8'h00, 0, 8'h78, 0, 1};
        vecs[10] = '{0, 8'h00, 0, 8'h78, 0, 1};
        vecs[11] = '{0, 8'h00, 0, 8'h78, 0, 1};
        vecs[12] = '{0, 8'h00, 0, 8'h00, 0, 1};
        vecs[13] = '{0, 8'h00, 0, 8'h00, 0, 1};
        vecs[14] = '{0, 8'h00, 0, 8'h00, 0, 0};
        vecs[15] = '{0, 8'h00, 0, 8'h00, 0, 0};

        // Reset values while rstb is held low.
        #12;
        chk("rst_outSel", int'(outSel), 0);
        chk("rst_outCount", int'(outCount), 0);
        chk("rst_outBusy", int'(outBusy), 0);
        chk("rst_outInvalid", int'(outInvalid), 0);
        @(negedge clk);
        rstb = 1'b1;
        #1;
        chk("rst_outReady", int'(outReady), 1);

        // Table: two keys, timing of hold, gap and busy.
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].v, vecs[i].k, vecs[i].f);
            chk("tbl_sel", int'(sSel), int'(vecs[i].sel));
            chk("tbl_cnt", sCnt, vecs[i].cnt);
            chk("tbl_busy", int'(sBusy), int'(vecs[i].busy));
        end

        // Six keys with inValid held: backpressure and ordering.
        t3keys = '{8'h7A, 8'h73, 8'h78, 8'h64, 8'h63, 8'h76};
        seen.delete();
        idx = 0;
        acc6 = -1;
        startT = t;
        for (int c = 0; c < 50; c++) begin
            step(idx < 6, (idx < 6) ? t3keys[idx] : 8'h00, 1'b0);
            if (lastAcc) begin
                if (idx == 5) acc6 = t - 1 - startT;
                idx++;
            end
            if (c == 5) chk("t3_full_ready", int'(outReady), 0);
        end
        chk("t3_accepted", idx, 6);
        chk("t3_sixth_cycle", acc6, 8);
        chk("t3_seen_n", seen.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("t3_order", (i < seen.size()) ? int'(seen[i]) : -1,
                int'(t3keys[i]));

        // Unmapped byte: accepted, flagged, not queued.
        step(1'b1, 8'h61, 1'b0);
        chk("t4_ready", int'(outReady), 1);
        step(1'b0, 8'h00, 1'b0);
        chk("t4_inv", int'(sInv), 1);
        chk("t4_cnt", sCnt, 0);
        step(1'b0, 8'h00, 1'b0);
        chk("t4_inv_off", int'(sInv), 0);
        chk("t4_sel", int'(sSel), 0);

        // Flush during HOLD with a mapped byte presented.
        seen.delete();
        step(1'b1, 8'h7A, 1'b0);
        step(1'b1, 8'h73, 1'b0);
        step(1'b1, 8'h78, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t5_in_hold", int'(sSel), 8'h7A);
        step(1'b1, 8'h6D, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("t5_sel", int'(sSel), 0);
        chk("t5_cnt", sCnt, 0);
        chk("t5_busy", int'(sBusy), 0);
        idle(20);
        chk("t5_seen_n", seen.size(), 1);

        // Asynchronous reset in the middle of a gap.
        step(1'b1, 8'h7A, 1'b0);
        step(1'b1, 8'h73, 1'b0);
        step(1'b1, 8'h78, 1'b0);
        idle(4);
        chk("t6_pre_cnt", int'(outCount), 2);
        inValid = 1'b0;
        inFlush = 1'b0;
        #1;
        rstb = 1'b0;
        #1;
        chk("t6_sel", int'(outSel), 0);
        chk("t6_cnt", int'(outCount), 0);
        chk("t6_busy", int'(outBusy), 0);
        chk("t6_inv", int'(outInvalid), 0);
        mReset();
        @(negedge clk);
        rstb = 1'b1;
        #1;
        chk("t6_ready", int'(outReady), 1);
        t++;
        seen.delete();
        idle(12);
        chk("t6_seen_n", seen.size(), 0);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            bit v;
            bit f;
            logic [7:0] k;
            v = ($urandom_range(0, 99) < 45);
            f = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) != 0)
                k = KEYS[$urandom_range(0, 11)];
            else
                k = 8'($urandom);
            step(v, k, f);
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
